pmbus_tlm_sched: RTL and testbench
==================================

PMBUS_TLM_SCHED -- requirements
Module: pmbus_tlm_sched

Interface
REQ-001 Parameter PERIOD, default 1000, SHALL set the number of clk cycles from entering WAIT to starting the next sweep; legal range 1..65535.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of cycles adc_req may stay high without adc_ack before the channel is abandoned; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state SHALL change on the rising edge only.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 EN  in  1  sweep enable; 1 runs sweeps, 0 idles the block.
REQ-006 dbusy  in  1  PMBus transaction in progress; while 1, published outputs SHALL stay frozen.
REQ-007 adc_ack  in  1  ADC conversion done; adc_data is valid in the same cycle.
REQ-008 adc_data  in  8  ADC conversion result.
REQ-009 err_clr  in  1  clears adc_err.
REQ-010 adc_req  out  1  conversion request, registered.
REQ-011 adc_ch  out  2  channel being converted: 0=vout, 1=iout, 2=tmp, 3=vin.
REQ-012 vout, iout, tmp, vin  out  8 each  published telemetry values, registered.
REQ-013 valid  out  1  one-cycle pulse marking a publish.
REQ-014 adc_err  out  1  sticky flag for an ADC timeout.

Function
REQ-015 The FSM SHALL have five states: IDLE, REQ, NEXT, PUBLISH and WAIT; it SHALL hold a 2-bit channel index, four 8-bit shadow registers, a timeout counter and a 16-bit period counter.
REQ-016 IDLE: if EN=1, the FSM SHALL go to REQ with channel 0.
REQ-017 REQ: adc_req SHALL be 1 and adc_ch SHALL equal the channel index.
REQ-018 REQ with adc_ack=1: adc_data SHALL be captured into the shadow register of the current channel.
  - channel < 3: go to NEXT.
  - channel = 3: go to PUBLISH.
REQ-019 REQ with the timeout counter at TIMEOUT-1 and adc_ack=0: adc_err SHALL be set, the shadow register SHALL keep its old value, and the FSM SHALL advance exactly as in REQ-018.
REQ-020 NEXT: adc_req SHALL be 0 for exactly one cycle; the channel index SHALL increment, and the FSM SHALL return to REQ with the timeout counter cleared.
REQ-021 PUBLISH with dbusy=0: all four shadow registers SHALL copy to the outputs in one edge, valid SHALL be 1 for that one cycle, and the FSM SHALL go to WAIT with the period counter at 0.
REQ-022 PUBLISH with dbusy=1: the FSM SHALL stay in PUBLISH; outputs stay unchanged and valid stays 0.
REQ-023 WAIT: the period counter SHALL increment every cycle; at PERIOD-1 the FSM SHALL go to REQ with channel 0, so that REQ is entered exactly PERIOD edges after WAIT was entered.
REQ-024 adc_ack SHALL be ignored in every state other than REQ.
REQ-025 Latency: EN sampled 1 in IDLE at edge N, with adc_ack returned in the first REQ cycle of every channel -> valid=1 after edge N+8.
REQ-026 EN=0 sampled in any state: the next state SHALL be IDLE.
  - adc_req drops to 0 on that edge.
  - The partial sweep is discarded and not published.
  - Published outputs keep their values.
REQ-027 err_clr=1 SHALL clear adc_err; if a timeout occurs in the same cycle, set SHALL win.
REQ-028 adc_ch SHALL hold its last value outside REQ.

Reset
REQ-029 rst=0 at an edge SHALL force:
  - state IDLE and channel 0;
  - adc_req, adc_ch, vout, iout, tmp, vin, valid and adc_err all 0;
  - shadow registers and both counters 0.
REQ-030 Reset SHALL take priority over all other inputs, including in mid-handshake.

Verification
REQ-031 Immediate-ack sweep: EN=1, dbusy=0, ADC returns 0x11/0x22/0x33/0x44 -> vout=0x11, iout=0x22, tmp=0x33, vin=0x44 and valid=1 after edge N+8; adc_req is low for one cycle between channels.
REQ-032 Timeout: with TIMEOUT=4, no ack on channel 2 -> adc_req high for 4 cycles, then adc_err=1 and tmp keeps its prior value; err_clr=1 with no timeout clears adc_err.
REQ-033 Freeze: dbusy=1 when PUBLISH is reached, held 10 cycles -> outputs unchanged and valid=0 throughout; publish occurs one edge after dbusy falls.
REQ-034 Period: PERIOD=5 -> adc_req rises for channel 0 exactly 5 edges after the valid pulse.
REQ-035 Abort and reset: EN=0 during channel 1 REQ -> adc_req=0 next cycle, IDLE, outputs retained; rst=0 mid-sweep -> all outputs 0 after one edge.

Source files
------------

// File: rtl/pmbus_tlm_sched_if.sv
// -----------------------------------------------------------------------------
// pmbus_tlm_sched_if
// Bundles the telemetry scheduler's control, ADC handshake and published
// telemetry signals.
//   slave  modport : the scheduler side (pmbus_tlm_sched)
//   master modport : whoever drives EN/dbusy/err_clr and answers the ADC
// Signals:
//   EN        sweep enable
//   dbusy     PMBus transaction in progress (freezes publishing)
//   adc_ack   ADC conversion done, adc_data valid in the same cycle
//   adc_data  ADC conversion result
//   err_clr   clears adc_err
//   adc_req   conversion request
//   adc_ch    channel being converted (0=vout 1=iout 2=tmp 3=vin)
//   vout/iout/tmp/vin  published telemetry
//   valid     one-cycle publish pulse
//   adc_err   sticky ADC timeout flag
// -----------------------------------------------------------------------------
interface pmbus_tlm_sched_if;
  logic       EN;
  logic       dbusy;
  logic       adc_ack;
  logic [7:0] adc_data;
  logic       err_clr;
  logic       adc_req;
  logic [1:0] adc_ch;
  logic [7:0] vout;
  logic [7:0] iout;
  logic [7:0] tmp;
  logic [7:0] vin;
  logic       valid;
  logic       adc_err;

  modport slave (
    input  EN, dbusy, adc_ack, adc_data, err_clr,
    output adc_req, adc_ch, vout, iout, tmp, vin, valid, adc_err
  );

  modport master (
    output EN, dbusy, adc_ack, adc_data, err_clr,
    input  adc_req, adc_ch, vout, iout, tmp, vin, valid, adc_err
  );
endinterface

// File: rtl/pmbus_tlm_sched.sv
// -----------------------------------------------------------------------------
// pmbus_tlm_sched
// Periodic PMBus telemetry scheduler. Sweeps four ADC channels
// (vout, iout, tmp, vin) into shadow registers, then publishes all four at
// once when the PMBus side is not busy, waits PERIOD cycles and repeats.
// A channel whose request is not acknowledged within TIMEOUT cycles is
// skipped (shadow keeps its old value) and flags the sticky adc_err.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-low reset
//   bus  pmbus_tlm_sched_if.slave (control, ADC handshake, telemetry)
// -----------------------------------------------------------------------------
module pmbus_tlm_sched #(
  parameter int unsigned PERIOD  = 1000,  // 1..65535
  parameter int unsigned TIMEOUT = 255    // 1..255
) (
  input  logic                  clk,
  input  logic                  rst,
  pmbus_tlm_sched_if.slave      bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_NEXT    = 3'd2;
  localparam logic [2:0] S_PUBLISH = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD - 1);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q,   state_d;
  logic [1:0]  chan_q,    chan_d;
  logic [7:0]  shadow_q [4];
  logic [7:0]  shadow_d [4];
  logic [7:0]  pub_q    [4];
  logic [7:0]  pub_d    [4];
  logic [7:0]  tcnt_q,    tcnt_d;
  logic [15:0] pcnt_q,    pcnt_d;
  logic        adc_req_q, adc_req_d;
  logic [1:0]  adc_ch_q,  adc_ch_d;
  logic        valid_q,   valid_d;
  logic        err_q,     err_d;
  logic        timeout;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    tcnt_d   = tcnt_q;
    pcnt_d   = pcnt_q;
    valid_d  = 1'b0;
    timeout  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shadow_d[i] = shadow_q[i];
      pub_d[i]    = pub_q[i];
    end

    // Dropping EN aborts from any state; nothing captured or published.
    if (!bus.EN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          chan_d  = 2'd0;
          tcnt_d  = 8'd0;
        end
        S_REQ: begin
          if (bus.adc_ack || (tcnt_q == TIMEOUT_LAST)) begin
            // Ack and timeout leave REQ the same way; only ack captures.
            if (bus.adc_ack) begin
              shadow_d[chan_q] = bus.adc_data;
            end else begin
              timeout = 1'b1;
            end
            state_d = (chan_q == 2'd3) ? S_PUBLISH : S_NEXT;
            tcnt_d  = 8'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
        S_NEXT: begin
          chan_d  = chan_q + 2'd1;
          tcnt_d  = 8'd0;
          state_d = S_REQ;
        end
        S_PUBLISH: begin
          if (!bus.dbusy) begin
            for (int i = 0; i < 4; i++) begin
              pub_d[i] = shadow_q[i];
            end
            valid_d = 1'b1;
            pcnt_d  = 16'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (pcnt_q == PERIOD_LAST) begin
            state_d = S_REQ;
            chan_d  = 2'd0;
            tcnt_d  = 8'd0;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Request and channel are registered from the next state so they line up
    // with the cycles the FSM actually spends in REQ.
    adc_req_d = (state_d == S_REQ);
    adc_ch_d  = (state_d == S_REQ) ? chan_d : adc_ch_q;

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      chan_q    <= 2'd0;
      tcnt_q    <= 8'd0;
      pcnt_q    <= 16'd0;
      adc_req_q <= 1'b0;
      adc_ch_q  <= 2'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 8'd0;
        pub_q[i]    <= 8'd0;
      end
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      adc_req_q <= adc_req_d;
      adc_ch_q  <= adc_ch_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        pub_q[i]    <= pub_d[i];
      end
    end
  end

  assign bus.adc_req = adc_req_q;
  assign bus.adc_ch  = adc_ch_q;
  assign bus.vout    = pub_q[0];
  assign bus.iout    = pub_q[1];
  assign bus.tmp     = pub_q[2];
  assign bus.vin     = pub_q[3];
  assign bus.valid   = valid_q;
  assign bus.adc_err = err_q;

endmodule

// File: tb/tb_pmbus_tlm_sched.sv
// -----------------------------------------------------------------------------
// tb_pmbus_tlm_sched
// Plays the ADC and PMBus side of pmbus_tlm_sched with randomized ack delays,
// data, busy windows, err_clr pulses, aborts and resets. Expected telemetry
// comes from a sweep-level model: per-channel shadow values, the published
// set and the error flag, updated from what the bench itself chose to do.
// -----------------------------------------------------------------------------
module tb_pmbus_tlm_sched;
  localparam int PERIOD  = 5;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  pmbus_tlm_sched_if bus ();

  pmbus_tlm_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  logic [7:0] m_shadow [4];
  logic [7:0] m_pub    [4];
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_pub();
    return {m_pub[0], m_pub[1], m_pub[2], m_pub[3]};
  endfunction

  function automatic logic [31:0] obs_pub();
    return {bus.vout, bus.iout, bus.tmp, bus.vin};
  endfunction

  // One clock; err_clr is pulsed at random and the error flag is checked.
  task automatic step(input bit to_edge);
    bus.err_clr = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    #1;
    if (to_edge) m_err = 1'b1;
    else if (bus.err_clr) m_err = 1'b0;
    check("adc_err", 32'(bus.adc_err), 32'(m_err));
  endtask

  // Entered with the DUT requesting channel k. d < TIMEOUT: ack after d idle
  // cycles; d >= TIMEOUT: never ack, channel times out.
  task automatic do_channel(input int k, input int d, input logic [7:0] data);
    check("req_enter", 32'(bus.adc_req), 32'd1);
    check("req_ch", 32'(bus.adc_ch), 32'(k));
    if (d < TIMEOUT) begin
      for (int i = 0; i < d; i++) begin
        bus.adc_ack = 1'b0; bus.adc_data = 8'($urandom); bus.dbusy = 1'($urandom);
        step(1'b0);
        check("req_hold", 32'(bus.adc_req), 32'd1);
      end
      bus.adc_ack = 1'b1; bus.adc_data = data;
      step(1'b0);
      m_shadow[k] = data;
    end else begin
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        bus.adc_ack = 1'b0; bus.adc_data = 8'($urandom); bus.dbusy = 1'($urandom);
        step(1'b0);
        check("req_hold", 32'(bus.adc_req), 32'd1);
      end
      bus.adc_ack = 1'b0;
      step(1'b1);
    end
    bus.adc_ack = 1'b0;
    if (k < 3) begin
      check("next_gap", 32'(bus.adc_req), 32'd0);
      check("ch_hold", 32'(bus.adc_ch), 32'(k));
      bus.adc_ack = 1'($urandom); bus.adc_data = 8'($urandom);
      step(1'b0);
      bus.adc_ack = 1'b0;
    end
  endtask

  // Entered in PUBLISH; hold dbusy for 'busy' cycles, then publish.
  task automatic do_publish(input int busy);
    check("pub_req_low", 32'(bus.adc_req), 32'd0);
    bus.dbusy = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      bus.adc_ack = 1'($urandom); bus.adc_data = 8'($urandom);
      step(1'b0);
      check("freeze_valid", 32'(bus.valid), 32'd0);
      check("freeze_out", obs_pub(), exp_pub());
    end
    bus.dbusy = 1'b0; bus.adc_ack = 1'b0;
    step(1'b0);
    for (int k = 0; k < 4; k++) m_pub[k] = m_shadow[k];
    check("valid", 32'(bus.valid), 32'd1);
    check("publish", obs_pub(), exp_pub());
  endtask

  // Entered right after the publish edge; REQ for channel 0 after PERIOD edges.
  task automatic do_wait();
    for (int i = 0; i < PERIOD - 1; i++) begin
      bus.adc_ack = 1'($urandom); bus.adc_data = 8'($urandom); bus.dbusy = 1'($urandom);
      step(1'b0);
      check("wait_req", 32'(bus.adc_req), 32'd0);
      check("wait_valid", 32'(bus.valid), 32'd0);
      check("wait_ch", 32'(bus.adc_ch), 32'd3);
    end
    bus.adc_ack = 1'($urandom); bus.adc_data = 8'($urandom);
    step(1'b0);
    bus.adc_ack = 1'b0; bus.dbusy = 1'b0;
    check("period_req", 32'(bus.adc_req), 32'd1);
    check("period_ch", 32'(bus.adc_ch), 32'd0);
    check("wait_out", obs_pub(), exp_pub());
  endtask

  task automatic full_sweep(input int id, input int dl [4], input logic [7:0] dt [4], input int busy);
    for (int k = 0; k < 4; k++) do_channel(k, dl[k], dt[k]);
    do_publish(busy);
    $display("sweep %0d: delays %0d/%0d/%0d/%0d busy %0d -> vout=%02h iout=%02h tmp=%02h vin=%02h err=%0d",
             id, dl[0], dl[1], dl[2], dl[3], busy, bus.vout, bus.iout, bus.tmp, bus.vin, bus.adc_err);
    do_wait();
  endtask

  task automatic abort_sweep(input int id);
    int ka;
    int da;
    ka = $urandom_range(0, 3);
    for (int k = 0; k < ka; k++) do_channel(k, $urandom_range(0, TIMEOUT), 8'($urandom));
    check("abort_ch", 32'(bus.adc_ch), 32'(ka));
    da = $urandom_range(0, TIMEOUT - 2);
    for (int i = 0; i < da; i++) begin
      bus.adc_ack = 1'b0;
      step(1'b0);
    end
    bus.EN = 1'b0;
    step(1'b0);
    check("abort_req", 32'(bus.adc_req), 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_out", obs_pub(), exp_pub());
    for (int i = 0; i < $urandom_range(1, 3); i++) begin
      bus.adc_ack = 1'($urandom); bus.adc_data = 8'($urandom);
      step(1'b0);
      check("idle_req", 32'(bus.adc_req), 32'd0);
      check("idle_ch", 32'(bus.adc_ch), 32'(ka));
      check("idle_out", obs_pub(), exp_pub());
    end
    bus.adc_ack = 1'b0; bus.EN = 1'b1;
    step(1'b0);
    check("restart_req", 32'(bus.adc_req), 32'd1);
    check("restart_ch", 32'(bus.adc_ch), 32'd0);
    $display("abort %0d: EN dropped on channel %0d after %0d cycles", id, ka, da);
  endtask

  task automatic reset_sweep(input int id);
    int kr;
    kr = $urandom_range(0, 3);
    for (int k = 0; k < kr; k++) do_channel(k, $urandom_range(0, TIMEOUT), 8'($urandom));
    // Reset lands on a cycle where the ADC is acknowledging; nothing is captured.
    rst = 1'b0; bus.err_clr = 1'b0;
    bus.adc_ack = 1'b1; bus.adc_data = 8'($urandom);
    @(posedge clk);
    #1;
    bus.adc_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 8'd0;
      m_pub[k]    = 8'd0;
    end
    m_err = 1'b0;
    check("rst_req", 32'(bus.adc_req), 32'd0);
    check("rst_ch", 32'(bus.adc_ch), 32'd0);
    check("rst_out", obs_pub(), exp_pub());
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_err", 32'(bus.adc_err), 32'(m_err));
    rst = 1'b1;
    step(1'b0);
    check("rst_restart", 32'(bus.adc_req), 32'd1);
    $display("reset %0d: rst asserted on channel %0d", id, kr);
  endtask

  initial begin
    int n_start;
    int dl [4];
    logic [7:0] dt [4];

    bus.EN = 1'b0; bus.dbusy = 1'b0; bus.adc_ack = 1'b0;
    bus.adc_data = 8'd0; bus.err_clr = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 8'd0;
      m_pub[k]    = 8'd0;
    end
    m_err = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("init_req", 32'(bus.adc_req), 32'd0);
    check("init_ch", 32'(bus.adc_ch), 32'd0);
    check("init_out", obs_pub(), 32'd0);
    check("init_valid", 32'(bus.valid), 32'd0);
    check("init_err", 32'(bus.adc_err), 32'd0);

    // Immediate-ack sweep with latency measured from the EN sampling edge.
    rst = 1'b1; bus.EN = 1'b1;
    step(1'b0);
    n_start = cyc;
    dt = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) do_channel(k, 0, dt[k]);
    do_publish(0);
    check("latency", 32'(cyc - n_start), 32'd8);
    check("sweep_fixed", obs_pub(), 32'h11223344);
    $display("sweep 0: immediate ack -> vout=%02h iout=%02h tmp=%02h vin=%02h", bus.vout, bus.iout, bus.tmp, bus.vin);
    do_wait();

    // Channel 2 times out (tmp keeps 0x33) and publish is frozen for 10 cycles.
    dl = '{0, 1, TIMEOUT, 0};
    dt = '{8'h55, 8'h66, 8'h77, 8'h88};
    full_sweep(1, dl, dt, 10);
    check("timeout_tmp", 32'(bus.tmp), 32'h33);

    for (int s = 2; s < 32; s++) begin
      case ($urandom_range(0, 7))
        0: abort_sweep(s);
        1: reset_sweep(s);
        default: begin
          for (int k = 0; k < 4; k++) begin
            dl[k] = ($urandom_range(0, 4) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
            dt[k] = 8'($urandom);
          end
          full_sweep(s, dl, dt, $urandom_range(0, 3));
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
